if_stage_fetch: RTL and testbench

//  MIPS instruction-fetch stage plus IF/ID pipeline register, directly upstream of ID_control.

---
 rtl/mips_pkg.sv | 19 +
 rtl/if_stage_fetch_if_id_reg.sv | 51 +++++
 rtl/if_stage_fetch.sv | 147 ++++++++++++++
 tb/tb_if_stage_fetch.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS front-end definitions: field widths, NOP word,
// opcode slice position and the fetch FSM state encoding.
package mips_pkg;

    localparam int NB_PC     = 32;
    localparam int NB_INSTR  = 32;
    localparam int NB_OPCODE = 6;

    localparam logic [NB_INSTR-1:0] NOP_WORD = 32'h0000_0000;

    localparam int OPC_MSB = NB_INSTR - 1;
    localparam int OPC_LSB = NB_INSTR - NB_OPCODE;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_HOLD = 2'd3;

endpackage

// File: rtl/if_stage_fetch_if_id_reg.sv
// if_id_reg: IF/ID pipeline register with flush > stall > load priority.
// Ports: i_clk, i_reset, i_stall, i_flush, i_load, i_instr, i_pc_plus4
//        -> o_instr, o_opcode, o_pc_plus4, o_valid.
module if_id_reg
    import mips_pkg::*;
#(
    parameter int NB_PC     = mips_pkg::NB_PC,
    parameter int NB_INSTR  = mips_pkg::NB_INSTR,
    parameter int NB_OPCODE = mips_pkg::NB_OPCODE
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_stall,
    input  logic                 i_flush,
    input  logic                 i_load,
    input  logic [NB_INSTR-1:0]  i_instr,
    input  logic [NB_PC-1:0]     i_pc_plus4,
    output logic [NB_INSTR-1:0]  o_instr,
    output logic [NB_OPCODE-1:0] o_opcode,
    output logic [NB_PC-1:0]     o_pc_plus4,
    output logic                 o_valid
);

    logic [NB_INSTR-1:0] r_instr;
    logic [NB_PC-1:0]    r_pc_plus4;
    logic                r_valid;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_instr    <= NB_INSTR'(NOP_WORD);
            r_pc_plus4 <= '0;
            r_valid    <= 1'b0;
        end else if (i_flush) begin
            r_instr    <= NB_INSTR'(NOP_WORD);
            r_valid    <= 1'b0;
        end else if (!i_stall) begin
            // No new word while not stalled means a bubble goes to ID.
            r_valid <= i_load;
            if (i_load) begin
                r_instr    <= i_instr;
                r_pc_plus4 <= i_pc_plus4;
            end
        end
    end

    assign o_instr    = r_instr;
    assign o_opcode   = r_instr[NB_INSTR-1 -: NB_OPCODE];
    assign o_pc_plus4 = r_pc_plus4;
    assign o_valid    = r_valid;

endmodule

// File: rtl/if_stage_fetch.sv
// MIPS instruction fetch: PC, imem req/valid FSM, hold buffer, IF/ID register.
// Ports: i_clk, i_reset, i_stall, i_flush, i_redirect, i_redirect_pc,
//        o_imem_req, o_imem_addr, i_imem_valid, i_imem_rdata,
//        o_instr, o_opcode, o_pc_plus4, o_valid.
// IF_STAGE_PERF_CNT_EN adds o_perf_fetched and o_perf_stall counters.
module if_stage_fetch
    import mips_pkg::*;
#(
    parameter int                          NB_PC     = mips_pkg::NB_PC,
    parameter int                          NB_INSTR  = mips_pkg::NB_INSTR,
    parameter int                          NB_OPCODE = mips_pkg::NB_OPCODE,
    parameter logic [mips_pkg::NB_PC-1:0]  RESET_PC  = '0
`ifdef IF_STAGE_PERF_CNT_EN
    ,
    parameter int                          NB_PERF   = 32
`endif
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_stall,
    input  logic                 i_flush,
    input  logic                 i_redirect,
    input  logic [NB_PC-1:0]     i_redirect_pc,
    output logic                 o_imem_req,
    output logic [NB_PC-1:0]     o_imem_addr,
    input  logic                 i_imem_valid,
    input  logic [NB_INSTR-1:0]  i_imem_rdata,
    output logic [NB_INSTR-1:0]  o_instr,
    output logic [NB_OPCODE-1:0] o_opcode,
    output logic [NB_PC-1:0]     o_pc_plus4,
    output logic                 o_valid
`ifdef IF_STAGE_PERF_CNT_EN
    ,
    output logic [NB_PERF-1:0]   o_perf_fetched,
    output logic [NB_PERF-1:0]   o_perf_stall
`endif
);

    logic [1:0]          r_state;
    logic [1:0]          w_state_n;
    logic [NB_PC-1:0]    r_pc;
    logic [NB_PC-1:0]    r_addr;
    logic [NB_INSTR-1:0] r_hold;
    logic                r_squash;

    logic                w_req;
    logic                w_resp;
    logic                w_drop;
    logic                w_take_mem;
    logic                w_to_hold;
    logic                w_take_hold;
    logic                w_load;
    logic [NB_INSTR-1:0] w_word;
    logic [NB_PC-1:0]    w_addr_plus4;

    assign w_req        = (r_state == ST_REQ) && !i_stall;
    assign w_resp       = (r_state == ST_WAIT) && i_imem_valid;
    // A response is dead if a redirect arrived earlier or arrives now.
    assign w_drop       = w_resp && (r_squash || i_redirect);
    assign w_take_mem   = w_resp && !w_drop && !i_stall;
    assign w_to_hold    = w_resp && !w_drop && i_stall;
    assign w_take_hold  = (r_state == ST_HOLD) && !i_redirect && !i_stall;
    assign w_load       = w_take_mem || w_take_hold;
    assign w_word       = w_take_hold ? r_hold : i_imem_rdata;
    assign w_addr_plus4 = r_addr + NB_PC'(4);

    // In REQ the address comes straight from the PC; afterwards it is
    // frozen in r_addr so a redirect cannot disturb the outstanding fetch.
    assign o_imem_req  = w_req;
    assign o_imem_addr = (r_state == ST_REQ) ? r_pc : r_addr;

    always_comb begin
        w_state_n = r_state;
        unique case (r_state)
            ST_IDLE: w_state_n = ST_REQ;
            ST_REQ:  if (w_req) w_state_n = ST_WAIT;
            ST_WAIT: begin
                if (w_drop || w_take_mem) w_state_n = ST_REQ;
                else if (w_to_hold)       w_state_n = ST_HOLD;
            end
            ST_HOLD: if (i_redirect || !i_stall) w_state_n = ST_REQ;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state  <= ST_IDLE;
            r_pc     <= RESET_PC;
            r_addr   <= RESET_PC;
            r_hold   <= '0;
            r_squash <= 1'b0;
        end else begin
            r_state <= w_state_n;
            if (w_req)
                r_addr <= r_pc;
            if (w_to_hold)
                r_hold <= i_imem_rdata;
            if (w_resp)
                r_squash <= 1'b0;
            else if (i_redirect && (r_state == ST_WAIT || w_req))
                r_squash <= 1'b1;
            if (i_redirect)
                r_pc <= i_redirect_pc;
            else if (w_load)
                r_pc <= w_addr_plus4;
        end
    end

    if_id_reg #(
        .NB_PC     (NB_PC),
        .NB_INSTR  (NB_INSTR),
        .NB_OPCODE (NB_OPCODE)
    ) u_if_id (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_stall    (i_stall),
        .i_flush    (i_flush),
        .i_load     (w_load),
        .i_instr    (w_word),
        .i_pc_plus4 (w_addr_plus4),
        .o_instr    (o_instr),
        .o_opcode   (o_opcode),
        .o_pc_plus4 (o_pc_plus4),
        .o_valid    (o_valid)
    );

`ifdef IF_STAGE_PERF_CNT_EN
    logic [NB_PERF-1:0] r_perf_fetched;
    logic [NB_PERF-1:0] r_perf_stall;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_perf_fetched <= '0;
            r_perf_stall   <= '0;
        end else begin
            if (w_load && !i_flush)
                r_perf_fetched <= r_perf_fetched + NB_PERF'(1);
            if (i_stall)
                r_perf_stall <= r_perf_stall + NB_PERF'(1);
        end
    end

    assign o_perf_fetched = r_perf_fetched;
    assign o_perf_stall   = r_perf_stall;
`endif

endmodule

// File: tb/tb_if_stage_fetch.sv
// Self-checking bench for if_stage_fetch: memory responder model,
// scoreboard of expected IF/ID entries, table plus corner sequences.
module tb_if_stage_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, flush, redir;
    logic [31:0] rpc;
    logic        imv;
    logic [31:0] imd;
    logic        req;
    logic [31:0] addr;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [31:0] pc4;
    logic        valid;
`ifdef IF_STAGE_PERF_CNT_EN
    logic [31:0] perf_f, perf_s;
`endif

    always #5 clk = ~clk;

    if_stage_fetch dut (
        .i_clk         (clk),
        .i_reset       (rst),
        .i_stall       (stall),
        .i_flush       (flush),
        .i_redirect    (redir),
        .i_redirect_pc (rpc),
        .o_imem_req    (req),
        .o_imem_addr   (addr),
        .i_imem_valid  (imv),
        .i_imem_rdata  (imd),
        .o_instr       (instr),
        .o_opcode      (opcode),
        .o_pc_plus4    (pc4),
        .o_valid       (valid)
`ifdef IF_STAGE_PERF_CNT_EN
        ,
        .o_perf_fetched(perf_f),
        .o_perf_stall  (perf_s)
`endif
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc4;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [5:0]  op;
        logic [31:0] pc4;
    } vec_t;

    exp_t        exp_q[$];
    logic [31:0] req_q[$];
    vec_t        vec[4];

    int          passes = 0;
    int          total  = 0;
    int          lat;
    int          cnt;
    bit          pend;
    bit          sq;
    bit          acc;
    int          nacc;
    logic [31:0] paddr;
    logic [31:0] si, sp;
    logic        sv;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: mem_word = 32'h0022_1020;
            32'h0000_0004: mem_word = 32'h8C43_0004;
            32'h0000_0008: mem_word = 32'h1000_0003;
            32'h0000_000C: mem_word = 32'h0800_0040;
            32'h0000_0100: mem_word = 32'hAC01_0008;
            32'hFFFF_FFFC: mem_word = 32'h2421_0001;
            default:       mem_word = {6'h08, a[25:0]};
        endcase
    endfunction

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic logic [31:0] pop_req();
        if (req_q.size() == 0) return 32'hDEAD_DEAD;
        return req_q.pop_front();
    endfunction

    // One clock: memory model at the falling edge, stimulus, request
    // capture, then scoreboard compare just after the rising edge.
    task automatic cyc(input bit s, input bit f, input bit r,
                       input logic [31:0] t);
        bit   resp;
        exp_t e;
        @(negedge clk);
        imv  = 1'b0;
        resp = 1'b0;
        if (pend) begin
            cnt--;
            if (cnt == 0) begin
                pend = 1'b0;
                resp = 1'b1;
                imv  = 1'b1;
                imd  = mem_word(paddr);
            end
        end
        stall = s;
        flush = f;
        redir = r;
        rpc   = t;
        if (resp) begin
            if (!(sq || r)) begin
                e.instr = mem_word(paddr);
                e.pc4   = paddr + 32'd4;
                exp_q.push_back(e);
            end
            sq = 1'b0;
        end else if (r && pend) begin
            sq = 1'b1;
        end
        #1;
        if (req) begin
            pend  = 1'b1;
            cnt   = lat;
            paddr = addr;
            req_q.push_back(addr);
            if (r) sq = 1'b1;
        end
        @(posedge clk);
        #1;
        acc = valid && !s;
        if (acc) begin
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL sb_unexpected: got instr %h, none expected", instr);
            end else begin
                e = exp_q.pop_front();
                check("sb_instr", instr, e.instr);
                check("sb_pc4", pc4, e.pc4);
                check("sb_opcode", {26'h0, opcode}, {26'h0, e.instr[31:26]});
            end
        end
    endtask

    task automatic run_until_acc(input string nm);
        for (int k = 0; k < 30; k++) begin
            cyc(1'b0, 1'b0, 1'b0, 32'h0);
            if (acc) break;
        end
        check(nm, {31'h0, acc}, 32'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0; redir = 1'b0;
        rpc = 32'h0; imv = 1'b0; imd = 32'h0;
        lat = 1; pend = 1'b0; sq = 1'b0; cnt = 0; paddr = 32'h0;

        vec[0] = '{32'h0000_0000, 6'h00, 32'h0000_0004};
        vec[1] = '{32'h0000_0004, 6'h23, 32'h0000_0008};
        vec[2] = '{32'h0000_0008, 6'h04, 32'h0000_000C};
        vec[3] = '{32'h0000_000C, 6'h02, 32'h0000_0010};

        repeat (2) @(negedge clk);
        check("rst_req", {31'h0, req}, 32'h0);
        check("rst_addr", addr, 32'h0);
        check("rst_instr", instr, 32'h0);
        check("rst_opcode", {26'h0, opcode}, 32'h0);
        check("rst_pc4", pc4, 32'h0);
        check("rst_valid", {31'h0, valid}, 32'h0);
        rst = 1'b0;

        // Sequential fetch with latency 1
        foreach (vec[i]) begin
            run_until_acc("t1_accept");
            check("t1_req_addr", pop_req(), vec[i].addr);
            check("t1_opcode", {26'h0, opcode}, {26'h0, vec[i].op});
            check("t1_pc4", pc4, vec[i].pc4);
        end

        // Stall while the response arrives: word parks in the hold buffer
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        si = instr; sp = pc4; sv = valid;
        nacc = 0;
        for (int k = 0; k < 2; k++) begin
            cyc(1'b1, 1'b0, 1'b0, 32'h0);
            check("t2_instr_held", instr, si);
            check("t2_pc4_held", pc4, sp);
            check("t2_valid_held", {31'h0, valid}, {31'h0, sv});
        end
        check("t2_no_new_req", req_q.size(), 1);
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        check("t2_release_accept", {31'h0, acc}, 32'h1);
        check("t2_pc4", pc4, 32'h14);
        check("t2_req_addr", pop_req(), 32'h10);

        // Redirect while waiting: pending word must vanish
        lat = 3;
        nacc = 0;
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        nacc += int'(acc);
        cyc(1'b0, 1'b0, 1'b1, 32'h100);
        nacc += int'(acc);
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        nacc += int'(acc);
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        nacc += int'(acc);
        check("t3_discarded", nacc, 0);
        run_until_acc("t3_accept");
        check("t3_req_old", pop_req(), 32'h14);
        check("t3_req_target", pop_req(), 32'h100);
        check("t3_pc4", pc4, 32'h104);
        check("t3_opcode", {26'h0, opcode}, 32'h2B);

        // Flush beats stall
        check("t4_pre_valid", {31'h0, valid}, 32'h1);
        cyc(1'b1, 1'b1, 1'b0, 32'h0);
        check("t4_valid", {31'h0, valid}, 32'h0);
        check("t4_instr", instr, 32'h0);
        check("t4_opcode", {26'h0, opcode}, 32'h0);

        // PC wrap at the top of the address space
        lat = 1;
        req_q.delete();
        cyc(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        run_until_acc("t5_accept_top");
        check("t5_req_squashed", pop_req(), 32'h104);
        check("t5_req_top", pop_req(), 32'hFFFF_FFFC);
        check("t5_pc4_wrap", pc4, 32'h0);
        check("t5_opcode", {26'h0, opcode}, 32'h09);
        run_until_acc("t5_accept_zero");
        check("t5_req_wrap", pop_req(), 32'h0);
        check("t5_pc4_next", pc4, 32'h4);

        // Reset during WAIT, then a stale response while in IDLE
        lat = 4;
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        pend = 1'b0; sq = 1'b0;
        exp_q.delete(); req_q.delete();
        #1;
        check("t6_rst_req", {31'h0, req}, 32'h0);
        check("t6_rst_addr", addr, 32'h0);
        check("t6_rst_valid", {31'h0, valid}, 32'h0);
        check("t6_rst_instr", instr, 32'h0);
`ifdef IF_STAGE_PERF_CNT_EN
        check("t6_perf_fetched", perf_f, 32'h0);
        check("t6_perf_stall", perf_s, 32'h0);
`endif
        @(negedge clk);
        rst = 1'b0;
        imv = 1'b1;
        imd = 32'hDEAD_BEEF;
        #1;
        check("t6_idle_no_req", {31'h0, req}, 32'h0);
        @(posedge clk);
        #1;
        check("t6_late_ignored", {31'h0, valid}, 32'h0);
        run_until_acc("t6_accept");
        check("t6_first_req", pop_req(), 32'h0);
        check("t6_first_instr", instr, 32'h0022_1020);

        check("sb_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
